// File: rtl/axi_tb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_tb_pkg
// Purpose  : Shared AXI constants and the copy-master FSM state encoding used
//            by the testbench-side AXI initiators.
// Contents : AXI_BURST_INCR, AXI_RESP_OKAY, AXI_RESP_SLVERR, copy_state_e,
//            axi_size_of() helper.
// Revision : 1.0 - initial release
// ============================================================================
package axi_tb_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // A burst may not cross a 4 KiB page.
    localparam int unsigned AXI_PAGE_BYTES = 4096;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CHK  = 3'd1,
        ST_AR   = 3'd2,
        ST_R    = 3'd3,
        ST_AW   = 3'd4,
        ST_W    = 3'd5,
        ST_B    = 3'd6,
        ST_DONE = 3'd7
    } copy_state_e;

    // AxSIZE encoding for a full-width beat of data_wth bits.
    function automatic logic [2:0] axi_size_of(input int unsigned data_wth);
        return 3'($clog2(data_wth / 8));
    endfunction

endpackage
`default_nettype wire

// File: rtl/tb_beat_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_beat_buf
// Purpose  : Beat buffer for the copy master. Simple dual-port register array
//            with synchronous write and combinational read.
// Ports    : clk_i           - clock
//            we_i            - write enable (one beat per cycle)
//            waddr_i/wdata_i - write address / data
//            raddr_i         - read address
//            rdata_o         - read data (combinational from raddr_i)
// Revision : 1.0 - initial release
// ============================================================================
module tb_beat_buf #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WIDTH  = 256,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    // Storage carries no reset: contents are always written by the read phase
    // before the write phase consumes them.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/axi_copy_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_copy_master
// Purpose  : AXI4 initiator that copies one INCR burst from a source address
//            to a destination address: reads the burst into a local beat
//            buffer, then writes the buffer back out as a single burst.
// Ports    : clk_i, rst_i (async, active-low)
//            cmd_valid/cmd_ready, cmd_src, cmd_dst, cmd_len - copy command
//            done (1-cycle pulse), err (valid with done)     - completion
//            AW/W/B/AR/R                                     - AXI4 master
// Revision : 1.0 - initial release
// ============================================================================
module axi_copy_master
    import axi_tb_pkg::*;
#(
    parameter int unsigned ADDR_WTH  = 32,
    parameter int unsigned DATA_WTH  = 256,
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned BUF_DEPTH = 16,
    parameter int unsigned AXI_ID    = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // copy command
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WTH-1:0]   cmd_src,
    input  logic [ADDR_WTH-1:0]   cmd_dst,
    input  logic [7:0]            cmd_len,
    output logic                  done,
    output logic                  err,
    // AW
    output logic [ADDR_WTH-1:0]   awaddr,
    output logic [1:0]            awburst,
    output logic [3:0]            awcache,
    output logic [7:0]            awlen,
    output logic [ID_WIDTH-1:0]   awid,
    output logic                  awlock,
    output logic [2:0]            awprot,
    output logic [3:0]            awqos,
    output logic [3:0]            awregion,
    output logic [2:0]            awsize,
    output logic                  awvalid,
    input  logic                  awready,
    // W
    output logic [DATA_WTH-1:0]   wdata,
    output logic                  wlast,
    output logic [DATA_WTH/8-1:0] wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    // B
    input  logic [1:0]            bresp,
    input  logic [ID_WIDTH-1:0]   bid,
    input  logic                  bvalid,
    output logic                  bready,
    // AR
    output logic [ADDR_WTH-1:0]   araddr,
    output logic [1:0]            arburst,
    output logic [3:0]            arcache,
    output logic [7:0]            arlen,
    output logic [ID_WIDTH-1:0]   arid,
    output logic                  arlock,
    output logic [2:0]            arprot,
    output logic [3:0]            arqos,
    output logic [3:0]            arregion,
    output logic [2:0]            arsize,
    output logic                  arvalid,
    input  logic                  arready,
    // R
    input  logic [DATA_WTH-1:0]   rdata,
    input  logic                  rlast,
    input  logic [1:0]            rresp,
    input  logic [ID_WIDTH-1:0]   rid,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam int unsigned   c_beat_bytes = DATA_WTH / 8;
    localparam int unsigned   c_buf_aw     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [2:0]    c_axsize     = axi_size_of(DATA_WTH);
    localparam logic [ADDR_WTH-1:0] c_addr_mask = ~(ADDR_WTH'(c_beat_bytes - 1));
    localparam logic [31:0]   c_max_len    = 32'(BUF_DEPTH - 1);
    localparam logic [31:0]   c_page_bytes = 32'(AXI_PAGE_BYTES);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    copy_state_e           state_q, state_d;
    logic [ADDR_WTH-1:0]   src_q, src_d;
    logic [ADDR_WTH-1:0]   dst_q, dst_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            rcnt_q, rcnt_d;
    logic [7:0]            wcnt_q, wcnt_d;
    logic                  err_q, err_d;

    logic [31:0]           w_burst_bytes;
    logic [31:0]           w_src_end;
    logic [31:0]           w_dst_end;
    logic                  w_reject;
    logic                  w_r_hs;
    logic                  w_w_hs;
    logic                  w_r_last_beat;
    logic                  w_w_last_beat;
    logic [DATA_WTH-1:0]   w_buf_rdata;
    logic                  w_unused_ids;

    // IDs are not checked: only one transaction is ever outstanding.
    assign w_unused_ids = ^{bid, rid};

    // Page-crossing check works on the page offset; ending exactly on the
    // page boundary (end == 4096) is legal.
    assign w_burst_bytes = (32'(len_q) + 32'd1) * 32'(c_beat_bytes);
    assign w_src_end     = 32'(src_q[11:0]) + w_burst_bytes;
    assign w_dst_end     = 32'(dst_q[11:0]) + w_burst_bytes;
    assign w_reject      = (32'(len_q) > c_max_len)
                         | (w_src_end > c_page_bytes)
                         | (w_dst_end > c_page_bytes);

    assign w_r_hs        = (state_q == ST_R) & rvalid;
    assign w_w_hs        = (state_q == ST_W) & wready;
    assign w_r_last_beat = (rcnt_q == len_q);
    assign w_w_last_beat = (wcnt_q == len_q);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid)              state_d = ST_CHK;
            ST_CHK:  state_d = w_reject ? ST_DONE : ST_AR;
            ST_AR:   if (arready)                state_d = ST_R;
            ST_R:    if (rvalid && w_r_last_beat) state_d = ST_AW;
            ST_AW:   if (awready)                state_d = ST_W;
            ST_W:    if (wready && w_w_last_beat) state_d = ST_B;
            ST_B:    if (bvalid)                 state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (all handshake outputs are pure functions of state, so
    // an asynchronous reset drops them in the same instant)
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            ST_IDLE: cmd_ready = 1'b1;
            ST_AR:   arvalid   = 1'b1;
            ST_R:    rready    = 1'b1;
            ST_AW:   awvalid   = 1'b1;
            ST_W:    wvalid    = 1'b1;
            ST_B:    bready    = 1'b1;
            ST_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: cmd_ready = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers: command fields, beat counters, sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            rcnt_q <= '0;
            wcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            src_q  <= src_d;
            dst_q  <= dst_d;
            len_q  <= len_d;
            rcnt_q <= rcnt_d;
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        len_d  = len_q;
        rcnt_d = rcnt_q;
        wcnt_d = wcnt_q;
        err_d  = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    // Addresses are aligned to the beat size on capture.
                    src_d  = cmd_src & c_addr_mask;
                    dst_d  = cmd_dst & c_addr_mask;
                    len_d  = cmd_len;
                    rcnt_d = '0;
                    wcnt_d = '0;
                    err_d  = 1'b0;
                end
            end
            ST_CHK: err_d = w_reject;
            ST_R: begin
                if (rvalid) begin
                    rcnt_d = rcnt_q + 8'd1;
                    // A slave error or an rlast that disagrees with the
                    // requested length both poison the copy status.
                    err_d  = err_q | (rresp != AXI_RESP_OKAY)
                                   | (rlast != w_r_last_beat);
                end
            end
            ST_W: begin
                if (wready) begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            ST_B: begin
                if (bvalid) begin
                    err_d = err_q | (bresp != AXI_RESP_OKAY);
                end
            end
            default: err_d = err_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Beat buffer
    // ------------------------------------------------------------------
    tb_beat_buf #(
        .DEPTH  (BUF_DEPTH),
        .WIDTH  (DATA_WTH),
        .ADDR_W (c_buf_aw)
    ) u_buf (
        .clk_i   (clk_i),
        .we_i    (w_r_hs),
        .waddr_i (c_buf_aw'(rcnt_q)),
        .wdata_i (rdata),
        .raddr_i (c_buf_aw'(wcnt_q)),
        .rdata_o (w_buf_rdata)
    );

    // ------------------------------------------------------------------
    // AXI address/data channels
    // ------------------------------------------------------------------
    assign araddr   = src_q;
    assign arlen    = len_q;
    assign arsize   = c_axsize;
    assign arburst  = AXI_BURST_INCR;
    assign arid     = ID_WIDTH'(AXI_ID);
    assign arcache  = 4'd0;
    assign arlock   = 1'b0;
    assign arprot   = 3'd0;
    assign arqos    = 4'd0;
    assign arregion = 4'd0;

    assign awaddr   = dst_q;
    assign awlen    = len_q;
    assign awsize   = c_axsize;
    assign awburst  = AXI_BURST_INCR;
    assign awid     = ID_WIDTH'(AXI_ID);
    assign awcache  = 4'd0;
    assign awlock   = 1'b0;
    assign awprot   = 3'd0;
    assign awqos    = 4'd0;
    assign awregion = 4'd0;

    assign wdata    = w_buf_rdata;
    assign wstrb    = '1;
    assign wlast    = w_w_last_beat;

endmodule
`default_nettype wire

// File: tb/tb_axi_copy_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_copy_master
// Purpose  : Self-checking bench for axi_copy_master with a reactive AXI slave
//            memory model (pattern-preloaded, optional random stalls and
//            injected read errors).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_copy_master;
    import axi_tb_pkg::*;

    localparam int ADDR_WTH  = 32;
    localparam int DATA_WTH  = 256;
    localparam int ID_WIDTH  = 4;
    localparam int BUF_DEPTH = 16;
    localparam int BEAT      = DATA_WTH / 8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                  cmd_valid, cmd_ready, done, err;
    logic [ADDR_WTH-1:0]   cmd_src, cmd_dst;
    logic [7:0]            cmd_len;
    logic [ADDR_WTH-1:0]   awaddr, araddr;
    logic [1:0]            awburst, arburst, bresp, rresp;
    logic [3:0]            awcache, awqos, awregion, arcache, arqos, arregion;
    logic [7:0]            awlen, arlen;
    logic [ID_WIDTH-1:0]   awid, arid, bid, rid;
    logic                  awlock, arlock;
    logic [2:0]            awprot, arprot, awsize, arsize;
    logic                  awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic                  arvalid, arready, rlast, rvalid, rready;
    logic [DATA_WTH-1:0]   wdata, rdata;
    logic [DATA_WTH/8-1:0] wstrb;

    axi_copy_master #(
        .ADDR_WTH(ADDR_WTH), .DATA_WTH(DATA_WTH), .ID_WIDTH(ID_WIDTH),
        .BUF_DEPTH(BUF_DEPTH), .AXI_ID(0)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_src(cmd_src),
        .cmd_dst(cmd_dst), .cmd_len(cmd_len), .done(done), .err(err),
        .awaddr(awaddr), .awburst(awburst), .awcache(awcache), .awlen(awlen),
        .awid(awid), .awlock(awlock), .awprot(awprot), .awqos(awqos),
        .awregion(awregion), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bid(bid), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arburst(arburst), .arcache(arcache), .arlen(arlen),
        .arid(arid), .arlock(arlock), .arprot(arprot), .arqos(arqos),
        .arregion(arregion), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rresp(rresp), .rid(rid), .rvalid(rvalid),
        .rready(rready)
    );

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Preloaded memory content: every beat address has a distinct pattern.
    function automatic logic [DATA_WTH-1:0] pattern(input logic [31:0] a);
        logic [DATA_WTH-1:0] d;
        for (int k = 0; k < DATA_WTH / 32; k++) begin
            d[k*32 +: 32] = a ^ 32'(32'h1111_1111 * (k + 1));
        end
        return d;
    endfunction

    // ------------------------------------------------------------------
    // AXI slave memory model
    // ------------------------------------------------------------------
    logic [DATA_WTH-1:0] mem [logic [31:0]];

    function automatic logic [DATA_WTH-1:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : pattern(a);
    endfunction

    bit          slv_stall    = 1'b0;
    int          slv_err_beat = -1;
    bit          rd_active, b_pend, r_hs, b_hs;
    int          rd_cnt, rd_len, wr_cnt, wr_len;
    logic [31:0] rd_addr, wr_addr;
    int          ar_cnt = 0, aw_cnt = 0, arv_cycles = 0, awv_cycles = 0;
    int          wbeats = 0, wlast_bad = 0, wstrb_bad = 0;
    logic [31:0] last_araddr, last_awaddr;
    logic [7:0]  last_arlen, last_awlen;
    logic [2:0]  last_arsize, last_awsize;
    logic [1:0]  last_arburst, last_awburst;
    logic [ID_WIDTH-1:0] last_arid;

    initial begin
        arready = 0; rvalid = 0; rdata = '0; rlast = 0; rresp = 0; rid = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = '0;
        rd_active = 0; b_pend = 0; rd_cnt = 0; rd_len = 0; wr_cnt = 0; wr_len = 0;
        rd_addr = '0; wr_addr = '0;
        forever begin
            @(posedge clk_i);
            r_hs = rvalid && rready;
            b_hs = bvalid && bready;
            if (!rst_i) begin
                rd_active = 0; b_pend = 0; r_hs = 0; b_hs = 0;
            end else begin
                if (arvalid) arv_cycles++;
                if (awvalid) awv_cycles++;
                if (arvalid && arready) begin
                    ar_cnt++;
                    last_araddr = araddr; last_arlen = arlen; last_arsize = arsize;
                    last_arburst = arburst; last_arid = arid;
                    rd_addr = araddr; rd_len = int'(arlen); rd_cnt = 0; rd_active = 1;
                end
                if (r_hs) begin
                    if (rd_cnt == rd_len) rd_active = 0;
                    else rd_cnt++;
                end
                if (awvalid && awready) begin
                    aw_cnt++;
                    last_awaddr = awaddr; last_awlen = awlen; last_awsize = awsize;
                    last_awburst = awburst;
                    wr_addr = awaddr; wr_len = int'(awlen); wr_cnt = 0;
                end
                if (wvalid && wready) begin
                    mem[wr_addr + 32'(wr_cnt * BEAT)] = wdata;
                    wbeats++;
                    if (wlast != (wr_cnt == wr_len)) wlast_bad++;
                    if (wstrb != '1) wstrb_bad++;
                    if (wlast) b_pend = 1;
                    wr_cnt++;
                end
                if (b_hs) b_pend = 0;
            end
            #1;
            arready = slv_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            awready = slv_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            wready  = slv_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            // Once raised, rvalid holds until accepted.
            rvalid  = rd_active && ((rvalid && !r_hs) || !slv_stall
                                    || 1'($urandom_range(0, 1)));
            rdata   = mem_rd(rd_addr + 32'(rd_cnt * BEAT));
            rlast   = rd_active && (rd_cnt == rd_len);
            rresp   = (rd_active && rd_cnt == slv_err_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            bvalid  = b_pend;
        end
    end

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [7:0]  len;
        bit          stall;
        int          err_beat;
        bit          accept;
        bit          exp_err;
        logic [31:0] exp_ar;
        logic [31:0] exp_aw;
    } vec_t;

    vec_t vecs [10];

    task automatic run_copy(input string tag, input vec_t v);
        int  a0, w0, arv0, awv0, wb0, wl0, ws0, cyc, done_cyc, bad;
        bit  got_done;
        logic err_seen, arv_at2, ready_at1;
        slv_stall = v.stall; slv_err_beat = v.err_beat;
        a0 = ar_cnt; w0 = aw_cnt; arv0 = arv_cycles; awv0 = awv_cycles;
        wb0 = wbeats; wl0 = wlast_bad; ws0 = wstrb_bad;
        got_done = 0; done_cyc = 0; err_seen = 0; arv_at2 = 0;
        @(negedge clk_i);
        check({tag, "_idle_ready"}, cmd_ready, 1);
        cmd_valid = 1; cmd_src = v.src; cmd_dst = v.dst; cmd_len = v.len;
        @(negedge clk_i);
        cyc = 1;
        ready_at1 = cmd_ready;
        // Keep cmd_valid up with a different command while busy; it must be ignored.
        cmd_src = 32'hDEAD_BEE0; cmd_dst = 32'hBEEF_0000; cmd_len = 8'd0;
        while (!got_done && cyc < 2000) begin
            if (cyc == 2) begin
                arv_at2   = arvalid;
                cmd_valid = 0;
            end
            if (done) begin
                got_done = 1; done_cyc = cyc; err_seen = err;
            end else begin
                @(negedge clk_i);
                cyc++;
            end
        end
        cmd_valid = 0;
        check({tag, "_done_seen"}, got_done, 1);
        check({tag, "_err"}, err_seen, v.exp_err);
        check({tag, "_busy_ready"}, ready_at1, 0);
        check({tag, "_arvalid_at2"}, arv_at2, v.accept);
        check({tag, "_ar_count"}, ar_cnt - a0, v.accept);
        check({tag, "_aw_count"}, aw_cnt - w0, v.accept);
        if (got_done) begin
            @(negedge clk_i);
            check({tag, "_done_pulse"}, {done, cmd_ready}, 2'b01);
        end
        if (!v.accept) begin
            check({tag, "_reject_latency"}, done_cyc, 2);
            check({tag, "_no_axi_valid"}, (arv_cycles - arv0) + (awv_cycles - awv0), 0);
        end else begin
            check({tag, "_araddr"}, last_araddr, v.exp_ar);
            check({tag, "_arlen"}, last_arlen, v.len);
            check({tag, "_ar_fields"}, {last_arsize, last_arburst, last_arid}, {3'd5, 2'b01, 4'd0});
            check({tag, "_awaddr"}, last_awaddr, v.exp_aw);
            check({tag, "_awlen"}, last_awlen, v.len);
            check({tag, "_aw_fields"}, {last_awsize, last_awburst}, {3'd5, 2'b01});
            check({tag, "_w_beats"}, wbeats - wb0, int'(v.len) + 1);
            check({tag, "_wlast_wstrb"}, (wlast_bad - wl0) + (wstrb_bad - ws0), 0);
            bad = 0;
            for (int b = 0; b <= int'(v.len); b++) begin
                if (mem_rd(v.exp_aw + 32'(b * BEAT)) !== pattern(v.exp_ar + 32'(b * BEAT)))
                    bad++;
            end
            check({tag, "_readback"}, bad, 0);
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    int cyc_w, done_hits;

    initial begin
        //          src            dst            len    stl eb  acc err exp_ar         exp_aw
        vecs[0] = '{32'h8000_0000, 32'h8040_0000, 8'd3,  0, -1, 1, 0, 32'h8000_0000, 32'h8040_0000};
        vecs[1] = '{32'h8000_0FE0, 32'h8040_1000, 8'd0,  0, -1, 1, 0, 32'h8000_0FE0, 32'h8040_1000};
        vecs[2] = '{32'h8000_0FE0, 32'h8040_2000, 8'd1,  0, -1, 0, 1, 32'h0,         32'h0};
        vecs[3] = '{32'h8000_2000, 32'h8040_3000, 8'd16, 0, -1, 0, 1, 32'h0,         32'h0};
        vecs[4] = '{32'h8000_3000, 32'h8040_4000, 8'd3,  0,  1, 1, 1, 32'h8000_3000, 32'h8040_4000};
        vecs[5] = '{32'h8000_4000, 32'h8040_5000, 8'd15, 1, -1, 1, 0, 32'h8000_4000, 32'h8040_5000};
        vecs[6] = '{32'h8000_5000, 32'h8040_6FC0, 8'd2,  0, -1, 0, 1, 32'h0,         32'h0};
        vecs[7] = '{32'h8000_7013, 32'h8040_7005, 8'd1,  0, -1, 1, 0, 32'h8000_7000, 32'h8040_7000};
        vecs[8] = '{32'h8000_8000, 32'h8040_8E00, 8'd15, 1, -1, 1, 0, 32'h8000_8000, 32'h8040_8E00};
        vecs[9] = '{32'h8000_B000, 32'h8040_B000, 8'd3,  1,  3, 1, 1, 32'h8000_B000, 32'h8040_B000};

        cmd_valid = 0; cmd_src = '0; cmd_dst = '0; cmd_len = '0;
        rst_i = 0;
        repeat (3) @(negedge clk_i);
        check("reset_ctrl", {cmd_ready, done, err}, 3'b100);
        check("reset_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
        rst_i = 1;
        @(negedge clk_i);
        check("post_reset_idle", {cmd_ready, arvalid, awvalid}, 3'b100);

        for (int i = 0; i < 10; i++) begin
            run_copy($sformatf("v%0d", i), vecs[i]);
        end

        // Reset in the middle of the write phase.
        slv_stall = 1; slv_err_beat = -1;
        @(negedge clk_i);
        cmd_valid = 1; cmd_src = 32'h8000_9000; cmd_dst = 32'h8040_9000; cmd_len = 8'd3;
        @(negedge clk_i);
        cmd_valid = 0;
        cyc_w = 0;
        while (!wvalid && cyc_w < 1000) begin
            @(negedge clk_i);
            cyc_w++;
        end
        check("midw_reached", wvalid, 1);
        rst_i = 0;
        #1;
        check("midw_valids_drop", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
        done_hits = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (done) done_hits++;
        end
        rst_i = 1;
        @(negedge clk_i);
        check("midw_no_done", done_hits, 0);
        check("midw_ready_after", cmd_ready, 1);
        run_copy("post_rst", '{32'h8000_A000, 32'h8040_A000, 8'd3, 1, -1, 1, 0,
                               32'h8000_A000, 32'h8040_A000});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
